// File: rtl/rom_seq_pkg.sv
// Shared types and sizing for the ROM sequential reader.
package rom_seq_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned BUF_DEPTH  = 2;
    localparam int unsigned CNT_W      = 2;
    localparam int unsigned OCC_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/rom_seq_fifo2.sv
// Two-entry shift FIFO; entry 0 is always the head, so the head output is a plain register.
module rom_seq_fifo2
    import rom_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] e0_q, e1_q;
    logic              v0_q, v1_q;
    logic              do_pop;

    assign do_pop = pop & v0_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            e0_q <= '0;
            e1_q <= '0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else if (do_pop) begin
            if (push) begin
                if (v1_q) begin
                    e0_q <= e1_q;
                    e1_q <= push_data;
                end else begin
                    e0_q <= push_data;
                end
            end else begin
                // Keep the stale head when draining to empty; it is not valid anyway.
                e0_q <= v1_q ? e1_q : e0_q;
                v0_q <= v1_q;
                v1_q <= 1'b0;
            end
        end else if (push) begin
            if (!v0_q) begin
                e0_q <= push_data;
                v0_q <= 1'b1;
            end else if (!v1_q) begin
                e1_q <= push_data;
                v1_q <= 1'b1;
            end
        end
    end

    assign head  = e0_q;
    assign full  = v1_q;
    assign empty = ~v0_q;
    assign count = CNT_W'(v0_q) + CNT_W'(v1_q);

endmodule

// File: rtl/rom_seq_reader.sv
// Walks an address window of a synchronous ROM and streams the words out through a 2-entry buffer.
module rom_seq_reader
    import rom_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] len_m1,
    input  logic              loop,
    input  logic              stop,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              loop_q, loop_d;
    logic              inflight_q;
    logic              done_d;

    logic              fifo_full, fifo_empty, fifo_push;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop_c;
    logic [OCC_W-1:0]  occ_c;
    logic              issue_c;

    assign out_valid = ~fifo_empty;
    assign pop_c     = out_valid & out_ready;
    assign fifo_push = inflight_q & (~fifo_full | pop_c);

    // Words already committed (buffered, at the ROM, or in the ROM output stage), net of this cycle's pop.
    assign occ_c   = OCC_W'(fifo_count) + OCC_W'(rom_en) + OCC_W'(inflight_q) - OCC_W'(pop_c);
    assign issue_c = (state_q == RUN) && !stop && (occ_c < OCC_W'(BUF_DEPTH));

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        len_d   = len_q;
        loop_d  = loop_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    base_d  = start_addr;
                    cur_d   = start_addr;
                    rem_d   = len_m1;
                    len_d   = len_m1;
                    loop_d  = loop;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end else if (issue_c) begin
                    if (rem_q == '0) begin
                        if (loop_q) begin
                            cur_d = base_q;
                            rem_d = len_q;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        cur_d = cur_q + ADDR_W'(1);
                        rem_d = rem_q - ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!rom_en && !inflight_q && fifo_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_q == DRAIN) && (state_d == IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            cur_q      <= '0;
            rem_q      <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            inflight_q <= 1'b0;
            rom_en     <= 1'b0;
            rom_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cur_q      <= cur_d;
            rem_q      <= rem_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            inflight_q <= rom_en;
            rom_en     <= issue_c;
            if (issue_c) begin
                rom_addr <= cur_q;
            end
            busy       <= (state_d != IDLE);
            done       <= done_d;
        end
    end

    rom_seq_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (rom_data),
        .pop       (pop_c),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
